// File: rtl/fc_lcc_tb_pulse_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fc_lcc_tb_seq_pkg: shared types and command-decode helpers for the pulse sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fc_lcc_tb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } chan_state_e;

  // Abort-all code sits directly after the last channel code.
  localparam int unsigned ABORT_GAP = 0;

  function automatic logic [7:0] cmd_to_chan(input logic [7:0] cmd, input logic [7:0] base);
    return cmd - base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_lcc_tb_pulse_sequencer_if.sv
// ----------------------------------------------------------------------------
// fc_lcc_tb_pulse_sequencer_if: tb_service command strobe from the mailbox model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fc_lcc_tb_pulse_sequencer_if;
  logic       tb_service_cmd_valid;
  logic [7:0] tb_service_cmd;

  modport master (output tb_service_cmd_valid, output tb_service_cmd);
  modport slave  (input  tb_service_cmd_valid, input  tb_service_cmd);
endinterface

`default_nettype wire

// File: rtl/fc_lcc_tb_pulse_sequencer_chan.sv
// ----------------------------------------------------------------------------
// fc_lcc_tb_pulse_chan: one delay/hold force window with trigger queue.
// Option FC_LCC_TB_PULSE_RETRIGGER_EN: a trigger while busy restarts the window.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fc_lcc_tb_pulse_chan
  import fc_lcc_tb_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_PEND = 3
) (
  input  wire logic             clk,
  input  wire logic             cptra_rst_b,
  input  wire logic             trig_i,
  input  wire logic             abort_i,
  input  wire logic [CNT_W-1:0] delay_i,
  input  wire logic [CNT_W-1:0] hold_i,
  output logic                  force_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  drop_o
);

  localparam int unsigned      PEND_W   = $clog2(MAX_PEND + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  chan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              done_q, done_d;
  logic              launch;
  logic              win_end;

  // A window ends on the last ACTIVE cycle, or on the last DELAY cycle when hold is zero.
  assign win_end = (cnt_q == CNT_ONE) &&
                   ((state_q == ACTIVE) || ((state_q == DELAY) && (hold_q == '0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    drop_o  = 1'b0;
    launch  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      pend_d  = '0;
    end else if (state_q == IDLE) begin
      launch = trig_i || (pend_q != '0);
      if (!trig_i && (pend_q != '0)) pend_d = pend_q - PEND_ONE;
    end else begin
      if ((state_q == DELAY) && (cnt_q == CNT_ONE)) begin
        state_d = ACTIVE;
        cnt_d   = hold_q;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
`ifdef FC_LCC_TB_PULSE_RETRIGGER_EN
      if (trig_i) begin
        launch = 1'b1;
      end else if (win_end) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
`else
      // A trigger landing on the end cycle with nothing queued launches directly.
      if (trig_i && !(win_end && (pend_q == '0))) begin
        if (pend_q < PEND_MAX) pend_d = pend_q + PEND_ONE;
        else                   drop_o = 1'b1;
      end
      if (win_end) begin
        done_d = 1'b1;
        if (pend_q != '0) begin
          launch = 1'b1;
          pend_d = pend_d - PEND_ONE;
        end else if (trig_i) begin
          launch = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`endif
    end
    if (launch) begin
      hold_d = hold_i;
      if (delay_i != '0) begin
        state_d = DELAY;
        cnt_d   = delay_i;
      end else if (hold_i != '0) begin
        state_d = ACTIVE;
        cnt_d   = hold_i;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign force_en_o = (state_q == ACTIVE);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

`default_nettype wire

// File: rtl/fc_lcc_tb_pulse_sequencer.sv
// ----------------------------------------------------------------------------
// fc_lcc_tb_pulse_sequencer: tb_service command decoder driving NUM_CH force windows.
// Option FC_LCC_TB_PULSE_RETRIGGER_EN selects restart-on-retrigger channels.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fc_lcc_tb_pulse_sequencer
  import fc_lcc_tb_seq_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned MAX_PEND = 3,
  parameter logic [7:0]  CMD_BASE = 8'hC0
) (
  input  wire logic                    clk,
  input  wire logic                    cptra_rst_b,
  fc_lcc_tb_pulse_sequencer_if.slave   svc,
  input  wire logic [NUM_CH*CNT_W-1:0] cfg_delay_i,
  input  wire logic [NUM_CH*CNT_W-1:0] cfg_hold_i,
  output logic      [NUM_CH-1:0]       force_en_o,
  output logic      [NUM_CH-1:0]       busy_o,
  output logic      [NUM_CH-1:0]       done_o,
  output logic      [7:0]              drop_cnt_o
);

  localparam logic [7:0] ABORT_OFS = 8'(NUM_CH + ABORT_GAP);

  logic [7:0]        w_off;
  logic              w_in_rng;
  logic              w_abort;
  logic [NUM_CH-1:0] w_trig;
  logic [NUM_CH-1:0] w_drop;
  logic [7:0]        drop_cnt_q;

  assign w_off    = cmd_to_chan(svc.tb_service_cmd, CMD_BASE);
  assign w_in_rng = svc.tb_service_cmd_valid && (svc.tb_service_cmd >= CMD_BASE) &&
                    (w_off <= ABORT_OFS);
  assign w_abort  = w_in_rng && (w_off == ABORT_OFS);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign w_trig[i] = w_in_rng && (w_off == 8'(i));

    fc_lcc_tb_pulse_chan #(
      .CNT_W    (CNT_W),
      .MAX_PEND (MAX_PEND)
    ) u_chan (
      .clk         (clk),
      .cptra_rst_b (cptra_rst_b),
      .trig_i      (w_trig[i]),
      .abort_i     (w_abort),
      .delay_i     (cfg_delay_i[i*CNT_W +: CNT_W]),
      .hold_i      (cfg_hold_i[i*CNT_W +: CNT_W]),
      .force_en_o  (force_en_o[i]),
      .busy_o      (busy_o[i]),
      .done_o      (done_o[i]),
      .drop_o      (w_drop[i])
    );
  end

  // Only one channel can be commanded per cycle, so a single increment suffices.
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      drop_cnt_q <= '0;
    end else if ((|w_drop) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;

endmodule

`default_nettype wire
